// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle for serial_magnitude_comparator.
//   start          : request a compare (honoured only while the comparator is idle)
//   a, b           : W-bit unsigned operands, captured with the accepted start
//   busy           : comparison in progress (SHIFT or DONE)
//   done           : one-cycle completion pulse
//   a_gt_b/eq/lt   : registered one-hot verdict, held until the next accepted start
// master drives the request; slave is the comparator.
interface serial_magnitude_comparator_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         a_gt_b;
    logic         a_eq_b;
    logic         a_lt_b;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial W-bit unsigned magnitude comparator.
// Operands are captured on an accepted start, then one bit pair per clock (MSB first) is
// examined by a single one-bit comparator cell. The first differing bit ends the compare;
// if all W bits match the result is "equal".
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side), see serial_magnitude_comparator_if
module serial_magnitude_comparator #(
    parameter int unsigned W = 8
) (
    input logic                           clk,
    input logic                           rst_n,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gt_q, gt_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;

    // One-bit comparator cell on the current MSBs.
    logic bit_x, bit_y;
    logic bit_g, bit_e, bit_l;

    always_comb begin
        bit_x = sa_q[W-1];
        bit_y = sb_q[W-1];
        bit_g = bit_x & ~bit_y;
        bit_l = ~bit_x & bit_y;
        bit_e = ~(bit_x ^ bit_y);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StShift;
            end
            StShift: begin
                if (bit_g || bit_l || (bit_e && (cnt_q == '0))) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register, so they are glitch-free.
    always_comb begin
        bus.busy   = (state_q != StIdle);
        bus.done   = (state_q == StDone);
        bus.a_gt_b = gt_q;
        bus.a_eq_b = eq_q;
        bus.a_lt_b = lt_q;
    end

    // Datapath next values: operand shift registers, bit counter, verdict flags.
    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        cnt_d = cnt_q;
        gt_d  = gt_q;
        eq_d  = eq_q;
        lt_d  = lt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d  = bus.a;
                    sb_d  = bus.b;
                    cnt_d = CntW'(W - 1);
                    gt_d  = 1'b0;
                    eq_d  = 1'b0;
                    lt_d  = 1'b0;
                end
            end
            StShift: begin
                if (bit_g) begin
                    gt_d = 1'b1;
                end else if (bit_l) begin
                    lt_d = 1'b1;
                end else if (cnt_q == '0) begin
                    eq_d = 1'b1;
                end else begin
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            cnt_q <= '0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
            gt_q  <= gt_d;
            eq_q  <= eq_d;
            lt_q  <= lt_d;
        end
    end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: a W=8 instance for directed cases and a W=4
// instance for the full operand sweep. Expected verdict and latency are queued when a
// start is accepted and checked when done is seen.
module tb_serial_magnitude_comparator;
    typedef struct {
        logic [2:0] flags;  // {gt, eq, lt}
        int         lat;    // edges from acceptance to done visible
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc8 = 0;
    int   cyc4 = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    serial_magnitude_comparator_if #(.W(8)) bus8 ();
    serial_magnitude_comparator_if #(.W(4)) bus4 ();

    serial_magnitude_comparator #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_magnitude_comparator #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Verdict from an unsigned compare; latency from the highest differing bit.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
        exp_t r;
        r.flags = (a > b) ? 3'b100 : ((a < b) ? 3'b001 : 3'b010);
        r.lat = w;
        for (int i = 0; i < w; i++) begin
            if (a[i] != b[i]) r.lat = w - i;
        end
        return r;
    endfunction

    // Scoreboard: busy cycles counted per compare; done pops the expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cyc8 = 0;
            cyc4 = 0;
            q8.delete();
            q4.delete();
        end else begin
            if (bus8.busy) cyc8++;
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    check("spurious_done8", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    check("flags8", 32'({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b}),
                          32'(e.flags));
                    check("busy_cycles8", 32'(cyc8), 32'(e.lat + 1));
                end
                cyc8 = 0;
            end
            if (bus4.busy) cyc4++;
            if (bus4.done) begin
                if (q4.size() == 0) begin
                    check("spurious_done4", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("flags4", 32'({bus4.a_gt_b, bus4.a_eq_b, bus4.a_lt_b}),
                          32'(e.flags));
                    check("onehot4", 32'($countones({bus4.a_gt_b, bus4.a_eq_b,
                                                      bus4.a_lt_b})), 32'd1);
                    check("busy_cycles4", 32'(cyc4), 32'(e.lat + 1));
                end
                cyc4 = 0;
            end
        end
    end

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (bus8.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus8.busy) check("idle_timeout8", 32'd1, 32'd0);
        bus8.a = a;
        bus8.b = b;
        bus8.start = 1'b1;
        q8.push_back(model(8, a, b));
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        check("accept_busy8", 32'(bus8.busy), 32'd1);
        check("accept_clear8", 32'({bus8.a_gt_b, bus8.a_eq_b, bus8.a_lt_b}), 32'd0);
    endtask

    // start stays high so the next pair is accepted on the first idle edge.
    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        while (bus4.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus4.busy) check("idle_timeout4", 32'd1, 32'd0);
        bus4.a = a;
        bus4.b = b;
        bus4.start = 1'b1;
        q4.push_back(model(4, 8'(a), 8'(b)));
        @(posedge clk);
        #1;
        check("accept_busy4", 32'(bus4.busy), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q4.size() != 0) begin
            check("drain_timeout", 32'(q8.size() + q4.size()), 32'd0);
            q8.delete();
            q4.delete();
        end
        // A few idle cycles so any extra done pulse gets caught.
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus4.start = 1'b0;
        bus4.a = '0;
        bus4.b = '0;

        #2 rst_n = 1'b0;
        #10;
        check("reset_outs8", 32'({bus8.busy, bus8.done, bus8.a_gt_b, bus8.a_eq_b,
                                  bus8.a_lt_b}), 32'd0);
        check("reset_outs4", 32'({bus4.busy, bus4.done, bus4.a_gt_b, bus4.a_eq_b,
                                  bus4.a_lt_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a compare.
        start8(8'h80, 8'h81);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outs8", 32'({bus8.busy, bus8.done, bus8.a_gt_b, bus8.a_eq_b,
                                     bus8.a_lt_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // MSB differs, LSB differs, equal, then a fresh start clears the old verdict.
        start8(8'h80, 8'h7F);
        drain(40);
        start8(8'h54, 8'h55);
        drain(40);
        start8(8'hA5, 8'hA5);
        drain(40);
        start8(8'h00, 8'hFF);
        drain(40);

        // start pulsed mid-compare with new operands must be ignored.
        start8(8'h10, 8'h11);
        @(negedge clk);
        @(negedge clk);
        bus8.a = 8'hFF;
        bus8.b = 8'h00;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        drain(40);

        // Full W=4 sweep with start held high.
        for (int i = 0; i < 256; i++) begin
            start4(4'(i >> 4), 4'(i));
        end
        @(negedge clk);
        bus4.start = 1'b0;
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial N-bit magnitude comparator built around the existing one-bit comparator cell (`g`/`e`/`l` outputs). It sits directly downstream-of-operands / upstream-of-result for that cell: loads two W-bit operands on a start strobe, feeds one bit pair per clock (MSB first) into a single one-bit comparator instance, and accumulates a registered greater/equal/less verdict. Used wherever area matters more than latency; early-terminates at the first differing bit.

## Interface

Parameters:
- `W`, default 8: operand width in bits; legal range W ≥ 1.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start`  input  1  request compare; sampled only in IDLE.
- `a`  input  W  operand A; sampled on the edge that accepts `start`.
- `b`  input  W  operand B; sampled with `a`.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle completion pulse.
- `a_gt_b`  output  1  registered verdict A > B.
- `a_eq_b`  output  1  registered verdict A == B.
- `a_lt_b`  output  1  registered verdict A < B.

## Operation

- Internal: shift registers `sa`, `sb` (W bits), bit counter `cnt` (width max(1, clog2(W))), 2-bit state.
- One-bit comparator instance takes x = `sa[W-1]`, y = `sb[W-1]`; its g/e/l drive FSM decisions.
- States: IDLE, SHIFT, DONE.
- IDLE: `start`=1 → `sa`←`a`, `sb`←`b`, `cnt`←W-1, all three verdict flags cleared to 0, → SHIFT. `start`=0 → stay.
- SHIFT, each cycle:
  - g=1 → `a_gt_b`←1, → DONE.
  - l=1 → `a_lt_b`←1, → DONE.
  - e=1 and `cnt`=0 → `a_eq_b`←1, → DONE.
  - e=1 and `cnt`≠0 → `sa`,`sb` shift left by 1 (LSB filled 0), `cnt`←`cnt`-1, stay.
- DONE: `done`=1 for this cycle only, → IDLE. Verdict flags unchanged.
- Verdict flags hold until the next accepted `start` clears them; after any completion exactly one flag is 1 (one-hot).
- `start` in SHIFT or DONE ignored (no queuing); `a`/`b` changes after acceptance have no effect.
- Operands unsigned.

## Timing

- Reset (`rst_n`=0, any time, including mid-compare): state→IDLE immediately; `busy`=0, `done`=0, `a_gt_b`=`a_eq_b`=`a_lt_b`=0, `sa`=`sb`=0, `cnt`=0. Operation resumes on first edge after deassertion.
- Edge E0 accepts `start`; `busy` high from E0 onward.
- Highest differing bit index k: SHIFT lasts W-1-k+1 = W-k cycles; verdict flag and `done` both visible after edge E0+(W-k); `done` drops and `busy` drops after E0+(W-k)+1.
- Operands equal: SHIFT lasts W cycles; `a_eq_b` and `done` visible after E0+W.
- Minimum latency (MSB differs): `done` after E0+1. Maximum: `done` after E0+W.
- Back-to-back: earliest next acceptance is the edge where state returns to IDLE+1, i.e. `start` held high is re-accepted on the first edge with `busy`=0 sampled in IDLE.
- W=1: single SHIFT cycle, `cnt` stays 0; `done` after E0+1 in all cases.
- Verdict flags are registers; no combinational path from `a`/`b` to outputs.

## Test plan

- Reset: assert `rst_n`=0 mid-SHIFT (W=8, a=8'h80, b=8'h81) → all outputs 0 within reset, no `done` pulse afterward, next `start` behaves normally.
- MSB differ: W=8, a=8'h80, b=8'h7F → `a_gt_b`=1, `done` pulse 1 cycle after E0, `busy` 2 cycles total.
- LSB differ: a=8'h54, b=8'h55 → `a_lt_b`=1, `done` 8 cycles after E0.
- Equal: a=b=8'hA5 → `a_eq_b`=1, `done` 8 cycles after E0; then a=8'h00, b=8'hFF → flags cleared at acceptance, `a_lt_b`=1 after 1 cycle.
- Ignored start: pulse `start` with new operands during SHIFT of a=8'h10,b=8'h11 → result `a_lt_b`=1 from first operands only, single `done`.
- Exhaustive W=4 sweep of all 256 pairs, `start` held high → each result matches unsigned compare, one-hot flags, latency W-k or W.
